// File: rtl/mat_cache_seq_pkg.sv
// Shared types for the MatCache command sequencer: MatCache read/write
// operation encodings, the sequencer command opcode and the FSM states.
package mat_cache_seq_pkg;

   // MatCache read selector: a whole row or a whole column of one slot.
   typedef enum logic [0:0] {
      MAT_DATA_READ_ROW,
      MAT_DATA_READ_COL
   } MatDataReadOp_t;

   // MatCache write selector. TRANSPOSE is MatCache's internal in-place
   // transpose of a whole slot and ignores the write data.
   typedef enum logic [1:0] {
      MAT_DATA_WRITE_DISABLE,
      MAT_DATA_WRITE_ROW,
      MAT_DATA_WRITE_COL,
      MAT_DATA_WRITE_TRANSPOSE
   } MatDataWriteOp_t;

   // Matrix-move commands accepted by the sequencer.
   typedef enum logic [0:0] {
      MAT_SEQ_COPY,
      MAT_SEQ_TRANSPOSE
   } MatSeqOp_t;

   // Sequencer states.
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } MatSeqState_t;

   // Index width for n items; never below one bit so a 1-entry
   // dimension still yields a legal vector.
   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mat_cache_seq_if.sv
// Command handshake plus MatCache control bus of the sequencer.
// slave  : the sequencer (takes commands, drives MatCache controls)
// master : the decoder / MatCache side of the same signals
interface mat_cache_seq_if
   import mat_cache_seq_pkg::*;
#(
   parameter int WIDTH      = 128,
   parameter int CACHE_SIZE = 4
);

   localparam int WIDTH_ADDR_SIZE = addr_bits(WIDTH);
   localparam int CACHE_ADDR_SIZE = addr_bits(CACHE_SIZE);

   // Command handshake
   logic                       cmd_valid;
   logic                       cmd_ready;
   MatSeqOp_t                  cmd_op;
   logic [CACHE_ADDR_SIZE-1:0] cmd_src;
   logic [CACHE_ADDR_SIZE-1:0] cmd_dst;

   // Status
   logic                       busy;
   logic                       done;

   // MatCache read control
   MatDataReadOp_t             read_op;
   logic [CACHE_ADDR_SIZE-1:0] read_addr1;
   logic [CACHE_ADDR_SIZE-1:0] read_addr2;
   logic [WIDTH_ADDR_SIZE-1:0] read_param;

   // MatCache write control
   MatDataWriteOp_t            write_op;
   logic [CACHE_ADDR_SIZE-1:0] write_addr1;
   logic [CACHE_ADDR_SIZE-1:0] write_addr2;
   logic [WIDTH_ADDR_SIZE-1:0] write_param;

   modport master (
      output cmd_valid, cmd_op, cmd_src, cmd_dst,
      input  cmd_ready, busy, done,
      input  read_op, read_addr1, read_addr2, read_param,
      input  write_op, write_addr1, write_addr2, write_param
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst,
      output cmd_ready, busy, done,
      output read_op, read_addr1, read_addr2, read_param,
      output write_op, write_addr1, write_addr2, write_param
   );

endinterface

// File: rtl/mat_cache_seq.sv
// MatCache command sequencer. Takes one copy/transpose command at a time and
// walks the MatCache read/write controls row by row, one row per cycle
// (combinational read of row i, write of the same data at the clock edge).
// An in-place transpose uses MatCache's single-cycle whole-slot transpose,
// because moving rows into columns of the same slot would overwrite
// unread data. A same-slot copy performs no writes at all.
// Every control output is a register, so nothing on cmd_* reaches MatCache
// combinationally.
//
// Optional build macro MAT_CACHE_SEQ_PERF_EN adds perf_busy_cycles
// (saturating busy-cycle count) and perf_cmds (wrapping completed-command
// count) output ports.
module mat_cache_seq
   import mat_cache_seq_pkg::*;
#(
   parameter int WIDTH      = 128,
   parameter int CACHE_SIZE = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   mat_cache_seq_if.slave        bus
`ifdef MAT_CACHE_SEQ_PERF_EN
   ,
   output logic [31:0]           perf_busy_cycles,
   output logic [15:0]           perf_cmds
`endif
);

   localparam int WIDTH_ADDR_SIZE = addr_bits(WIDTH);
   localparam int CACHE_ADDR_SIZE = addr_bits(CACHE_SIZE);

   // Terminal compare is against WIDTH-1 rather than counter wrap, so a
   // non-power-of-2 WIDTH finishes after exactly WIDTH rows.
   localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_IDX = WIDTH_ADDR_SIZE'(WIDTH - 1);

   MatSeqState_t               state;
   MatSeqOp_t                  op_q;
   logic [CACHE_ADDR_SIZE-1:0] src_q;
   logic [CACHE_ADDR_SIZE-1:0] dst_q;
   logic [WIDTH_ADDR_SIZE-1:0] idx;
   logic                       in_place;

   logic                       cmd_ready_q;
   logic                       busy_q;
   logic                       done_q;
   MatDataReadOp_t             read_op_q;
   logic [CACHE_ADDR_SIZE-1:0] read_addr_q;
   logic [WIDTH_ADDR_SIZE-1:0] read_param_q;
   MatDataWriteOp_t            write_op_q;
   logic [CACHE_ADDR_SIZE-1:0] write_addr_q;
   logic [WIDTH_ADDR_SIZE-1:0] write_param_q;

   // A transpose onto its own source slot runs as one whole-slot operation.
   assign in_place = (op_q == MAT_SEQ_TRANSPOSE) && (src_q == dst_q);

   // Sequencer FSM with its index counter and registered control outputs.
   // Outputs for the next state are loaded on the same edge that enters it,
   // so RUN row 0 is already on the bus in the first cycle after accept.
   // NOTE: every register here uses <= so all updates within one edge read
   // the pre-edge values; a blocking = would let later lines see new values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         op_q          <= MAT_SEQ_COPY;
         src_q         <= '0;
         dst_q         <= '0;
         idx           <= '0;
         cmd_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         read_op_q     <= MAT_DATA_READ_ROW;
         read_addr_q   <= '0;
         read_param_q  <= '0;
         write_op_q    <= MAT_DATA_WRITE_DISABLE;
         write_addr_q  <= '0;
         write_param_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_q     <= 1'b0;
               write_op_q <= MAT_DATA_WRITE_DISABLE;
               if (bus.cmd_valid) begin
                  op_q          <= bus.cmd_op;
                  src_q         <= bus.cmd_src;
                  dst_q         <= bus.cmd_dst;
                  idx           <= '0;
                  cmd_ready_q   <= 1'b0;
                  busy_q        <= 1'b1;
                  read_op_q     <= MAT_DATA_READ_ROW;
                  read_addr_q   <= bus.cmd_src;
                  read_param_q  <= '0;
                  write_addr_q  <= bus.cmd_dst;
                  write_param_q <= '0;
                  if (bus.cmd_src != bus.cmd_dst) begin
                     state      <= RUN;
                     write_op_q <= (bus.cmd_op == MAT_SEQ_COPY) ? MAT_DATA_WRITE_ROW
                                                                 : MAT_DATA_WRITE_COL;
                  end else if (bus.cmd_op == MAT_SEQ_TRANSPOSE) begin
                     state      <= RUN;
                     write_op_q <= MAT_DATA_WRITE_TRANSPOSE;
                  end else begin
                     // Copy onto itself: nothing to move, report completion.
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (in_place || (idx == LAST_IDX)) begin
                  state      <= DONE;
                  done_q     <= 1'b1;
                  write_op_q <= MAT_DATA_WRITE_DISABLE;
               end else begin
                  idx           <= idx + 1'b1;
                  read_param_q  <= idx + 1'b1;
                  write_param_q <= idx + 1'b1;
               end
            end

            DONE: begin
               state       <= IDLE;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end

            default: begin
               state       <= IDLE;
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
               write_op_q  <= MAT_DATA_WRITE_DISABLE;
            end
         endcase
      end
   end

   // Both MatCache address ports always point at the same slot.
   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.read_op     = read_op_q;
   assign bus.read_addr1  = read_addr_q;
   assign bus.read_addr2  = read_addr_q;
   assign bus.read_param  = read_param_q;
   assign bus.write_op    = write_op_q;
   assign bus.write_addr1 = write_addr_q;
   assign bus.write_addr2 = write_addr_q;
   assign bus.write_param = write_param_q;

`ifdef MAT_CACHE_SEQ_PERF_EN
   // Busy-cycle counter saturates; completed-command counter wraps.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_busy_cycles <= '0;
         perf_cmds        <= '0;
      end else begin
         if (busy_q && (perf_busy_cycles != '1)) begin
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         end
         if (done_q) begin
            perf_cmds <= perf_cmds + 16'd1;
         end
      end
   end
`endif

endmodule
